// File: rtl/hazard_scoreboard.sv
// Per-register busy scoreboard for long-latency writes; drives the global decode stall.
// Optional HAZARD_SCOREBOARD_STATS_EN adds saturating stall and full-stall cycle counters.
module hazard_scoreboard #(
  parameter int REG_INDEX_WIDTH = 5,
  parameter int MAX_PENDING     = 4,
  parameter int WB_BYPASS       = 1,
  parameter int CHECK_WAW       = 1,
  localparam int NUM_REGS       = 2 ** REG_INDEX_WIDTH,
  localparam int CNT_W          = $clog2(MAX_PENDING + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REG_INDEX_WIDTH-1:0] rs1_index_decode,
  input  logic [REG_INDEX_WIDTH-1:0] rs2_index_decode,
  input  logic [REG_INDEX_WIDTH-1:0] rd_index_decode,
  input  logic                       rd_write_decode,
  input  logic                       issue_valid_execute,
  input  logic                       issue_long_latency_execute,
  input  logic [REG_INDEX_WIDTH-1:0] rd_index_execute,
  input  logic                       flush_execute,
  input  logic                       writeback_valid,
  input  logic [REG_INDEX_WIDTH-1:0] rd_index_writeback,
  output logic                       stall_pipeline,
  output logic [NUM_REGS-1:0]        busy_vector,
  output logic [CNT_W-1:0]           pending_count,
  output logic                       scoreboard_full
`ifdef HAZARD_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]                stall_cycle_count,
  output logic [31:0]                full_stall_count
`endif
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    pending_q, pending_d;
  logic [NUM_REGS-1:0] busy_eff;
  logic                set_en, clr_en;
  logic                inc, dec;
  logic                cause_raw, cause_ex, cause_waw, cause_full;

  always_comb begin
    set_en = issue_valid_execute && issue_long_latency_execute && !flush_execute
             && (rd_index_execute != '0);
    clr_en = writeback_valid && (rd_index_writeback != '0) && busy_q[rd_index_writeback];
  end

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[rd_index_writeback] = 1'b0;
    if (set_en) busy_d[rd_index_execute] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // A set and clear on the same register cancel out in the count (set wins the bit).
  always_comb begin
    inc       = set_en && !busy_q[rd_index_execute];
    dec       = clr_en && !(set_en && (rd_index_execute == rd_index_writeback));
    pending_d = pending_q;
    if (inc && !dec) pending_d = pending_q + CNT_W'(1);
    else if (dec && !inc) pending_d = pending_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= '0;
      pending_q <= '0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  end

  // A same-cycle writeback is forwarded, so its register no longer hazards.
  always_comb begin
    busy_eff = busy_q;
    if ((WB_BYPASS != 0) && clr_en) busy_eff[rd_index_writeback] = 1'b0;
  end

  always_comb begin
    cause_raw  = busy_eff[rs1_index_decode] || busy_eff[rs2_index_decode];
    cause_ex   = set_en && ((rd_index_execute == rs1_index_decode) ||
                            (rd_index_execute == rs2_index_decode));
    cause_waw  = (CHECK_WAW != 0) && rd_write_decode && (rd_index_decode != '0) &&
                 (busy_eff[rd_index_decode] ||
                  (set_en && (rd_index_execute == rd_index_decode)));
    cause_full = scoreboard_full && !clr_en;
    stall_pipeline = !rst && (cause_raw || cause_ex || cause_waw || cause_full);
  end

  assign busy_vector     = busy_q;
  assign pending_count   = pending_q;
  assign scoreboard_full = (pending_q == CNT_W'(MAX_PENDING));

`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] full_cnt_q, full_cnt_d;
  logic        full_only;

  always_comb begin
    full_only   = cause_full && !cause_raw && !cause_ex && !cause_waw;
    stall_cnt_d = stall_cnt_q;
    full_cnt_d  = full_cnt_q;
    if (stall_pipeline && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (full_only && (full_cnt_q != 32'hFFFF_FFFF)) full_cnt_d = full_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      full_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      full_cnt_q  <= full_cnt_d;
    end
  end

  assign stall_cycle_count = stall_cnt_q;
  assign full_stall_count  = full_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized checks of hazard_scoreboard against a set-of-busy-registers model.
module tb_hazard_scoreboard;
  localparam int RIW = 5;
  localparam int NR  = 32;
  localparam int MP  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [RIW-1:0] rs1, rs2, rd_dec, rd_ex, rd_wb;
  logic           rd_write, issue_v, issue_ll, flush, wb_v;
  logic           stall;
  logic [NR-1:0]  busy_vec;
  logic [2:0]     pend;
  logic           full;
`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic [31:0]    stall_cnt, full_cnt;
  int             m_stall_cnt, m_full_cnt;
`endif

  int errors = 0;
  int checks = 0;
  bit m_busy[NR];

  hazard_scoreboard dut (
    .clk(clk), .rst(rst),
    .rs1_index_decode(rs1), .rs2_index_decode(rs2),
    .rd_index_decode(rd_dec), .rd_write_decode(rd_write),
    .issue_valid_execute(issue_v), .issue_long_latency_execute(issue_ll),
    .rd_index_execute(rd_ex), .flush_execute(flush),
    .writeback_valid(wb_v), .rd_index_writeback(rd_wb),
    .stall_pipeline(stall), .busy_vector(busy_vec),
    .pending_count(pend), .scoreboard_full(full)
`ifdef HAZARD_SCOREBOARD_STATS_EN
    , .stall_cycle_count(stall_cnt), .full_stall_count(full_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int r = 0; r < NR; r++) n += m_busy[r];
    return n;
  endfunction

  function automatic logic [NR-1:0] m_vec();
    logic [NR-1:0] v = '0;
    for (int r = 0; r < NR; r++) v[r] = m_busy[r];
    return v;
  endfunction

  task automatic idle();
    rs1 = '0; rs2 = '0; rd_dec = '0; rd_write = 0;
    issue_v = 0; issue_ll = 0; rd_ex = '0; flush = 0;
    wb_v = 0; rd_wb = '0;
  endtask

  task automatic issue(input int r);
    issue_v = 1; issue_ll = 1; rd_ex = RIW'(r);
  endtask

  task automatic writeback(input int r);
    wb_v = 1; rd_wb = RIW'(r);
  endtask

  // One cycle: model-predicted stall before the edge, registered state after it.
  task automatic step();
    bit se, ce, es, raw, exm, waw, fc;
    se  = issue_v && issue_ll && !flush && (rd_ex != 0);
    ce  = wb_v && (rd_wb != 0) && m_busy[rd_wb];
    raw = (m_busy[rs1] && !(ce && rd_wb == rs1)) || (m_busy[rs2] && !(ce && rd_wb == rs2));
    exm = se && (rd_ex == rs1 || rd_ex == rs2);
    waw = rd_write && (rd_dec != 0) &&
          ((m_busy[rd_dec] && !(ce && rd_wb == rd_dec)) || (se && rd_ex == rd_dec));
    fc  = (m_count() == MP) && !ce;
    es  = raw || exm || waw || fc;
    #1;
    check("stall", stall, es);
`ifdef HAZARD_SCOREBOARD_STATS_EN
    if (es) m_stall_cnt++;
    if (fc && !raw && !exm && !waw) m_full_cnt++;
`endif
    @(posedge clk);
    if (ce) m_busy[rd_wb] = 0;
    if (se) m_busy[rd_ex] = 1;
    #1;
    check("busy_vector", busy_vec, m_vec());
    check("pending_count", pend, m_count());
    check("scoreboard_full", full, m_count() == MP);
`ifdef HAZARD_SCOREBOARD_STATS_EN
    check("stall_cycle_count", stall_cnt, m_stall_cnt);
    check("full_stall_count", full_cnt, m_full_cnt);
`endif
  endtask

  initial begin
    idle();
    rst = 1;
    #2;
    check("rst_stall", stall, 0);
    check("rst_busy", busy_vec, 0);
    check("rst_pending", pend, 0);
    check("rst_full", full, 0);
    #10 rst = 0;

    // Load-use on rd=5, then forwarded writeback
    idle(); issue(5); step();
    idle(); rs1 = 5; #1;
    check("t1_stall", stall, 1);
    check("t1_busy5", busy_vec[5], 1);
    check("t1_pending", pend, 1);
    step();
    idle(); rs1 = 5; writeback(5); #1;
    check("t2_stall_bypass", stall, 0);
    step();
    check("t2_busy5", busy_vec[5], 0);
    check("t2_pending", pend, 0);

    // Fill to MAX_PENDING
    for (int r = 1; r <= 4; r++) begin idle(); issue(r); step(); end
    idle(); rs1 = 10; #1;
    check("t3_full", full, 1);
    check("t3_stall_full", stall, 1);
    writeback(2); #1;
    check("t3_stall_wb", stall, 0);
    step();
    check("t3_pending", pend, 3);
    for (int r = 1; r <= 4; r++) begin
      if (r != 2) begin idle(); writeback(r); step(); end
    end

    // x0 never hazards; writeback of a non-busy reg is ignored
    idle(); issue(0); rs1 = 0; #1;
    check("t4_stall_x0", stall, 0);
    step();
    check("t4_busy_x0", busy_vec, 0);
    idle(); writeback(9); step();
    check("t4_pending", pend, 0);

    // Flushed issue does not set
    idle(); issue(7); flush = 1; rs2 = 7; #1;
    check("t5_stall", stall, 0);
    step();
    check("t5_busy7", busy_vec[7], 0);

    // Randomized traffic over a small register window to provoke hits
    for (int i = 0; i < 400; i++) begin
      idle();
      rs1      = RIW'($urandom_range(0, 7));
      rs2      = RIW'($urandom_range(0, 7));
      rd_dec   = RIW'($urandom_range(0, 7));
      rd_write = 1'($urandom_range(0, 1));
      issue_v  = 1'($urandom_range(0, 1));
      issue_ll = (m_count() < MP) ? 1'($urandom_range(0, 1)) : 1'b0;
      rd_ex    = RIW'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 7) == 0);
      wb_v     = 1'($urandom_range(0, 1));
      rd_wb    = RIW'($urandom_range(0, 7));
      step();
    end

    // WAW stall, then asynchronous reset mid-stall
    idle(); issue(3); step();
    idle(); rd_dec = 3; rd_write = 1; #1;
    check("t6_waw_stall", stall, 1);
    rst = 1; #1;
    check("t6_rst_stall", stall, 0);
    check("t6_rst_busy", busy_vec, 0);
    check("t6_rst_pending", pend, 0);
    check("t6_rst_full", full, 0);
`ifdef HAZARD_SCOREBOARD_STATS_EN
    check("t6_rst_stall_cnt", stall_cnt, 0);
    m_stall_cnt = 0; m_full_cnt = 0;
`endif
    for (int r = 0; r < NR; r++) m_busy[r] = 0;
    #3 rst = 0;
    idle(); writeback(3); step();
    check("t6_late_wb_pending", pend, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
